// File: rtl/cycle_controller.sv
// Multi-cycle processor control FSM: sequences fetch/decode/execute/memory/writeback,
// decodes Mealy strobes and selects, and tracks retired instructions and sticky errors.
module cycle_controller #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic        halt,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_load,
  output logic        pc_load,
  output logic        reg_write,
  output logic        alu_src_imm,
  output logic        reg_dst_rd,
  output logic        mem_to_reg,
  output logic [1:0]  pc_src,
  output logic [2:0]  state,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic        timeout,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALTED    = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;

  // The counter only ever holds 0..TIMEOUT-1; the last wait cycle is detected before the increment.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t        cur;
  state_t        nxt;
  logic [CW-1:0] wait_cnt;
  logic          set_illegal;
  logic          set_timeout;
  logic          retire;

  logic is_rtype, is_syscall, is_addi, is_lw, is_sw, is_beq, is_j, is_legal;

  assign is_rtype   = (opcode == OP_RTYPE);
  assign is_syscall = is_rtype && (func == FN_SYSCALL);
  assign is_addi    = (opcode == OP_ADDI);
  assign is_lw      = (opcode == OP_LW);
  assign is_sw      = (opcode == OP_SW);
  assign is_beq     = (opcode == OP_BEQ);
  assign is_j       = (opcode == OP_J);
  assign is_legal   = is_rtype | is_addi | is_lw | is_sw | is_beq | is_j;

  always_comb begin
    nxt         = cur;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    reg_write   = 1'b0;
    alu_src_imm = 1'b0;
    reg_dst_rd  = 1'b0;
    mem_to_reg  = 1'b0;
    pc_src      = 2'd0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    unique case (cur)
      S_IDLE: begin
        if (run && !halt) nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          nxt     = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          set_timeout = 1'b1;
          nxt         = S_ERROR;
        end
      end
      S_DECODE: begin
        if (is_syscall) begin
          pc_load = 1'b1;
          nxt     = S_HALTED;
        end else if (is_legal) begin
          nxt = S_EXECUTE;
        end else begin
          set_illegal = 1'b1;
          pc_load     = 1'b1;
          nxt         = halt ? S_IDLE : S_FETCH;
        end
      end
      S_EXECUTE: begin
        alu_src_imm = is_addi | is_lw | is_sw;
        if (is_beq) begin
          pc_load = 1'b1;
          pc_src  = alu_zero ? 2'd1 : 2'd0;
          nxt     = halt ? S_IDLE : S_FETCH;
        end else if (is_j) begin
          pc_load = 1'b1;
          pc_src  = 2'd2;
          nxt     = halt ? S_IDLE : S_FETCH;
        end else if (is_lw || is_sw) begin
          nxt = S_MEMORY;
        end else begin
          nxt = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        alu_src_imm = 1'b1;
        mem_read    = is_lw;
        mem_write   = is_sw;
        if (mem_ready) begin
          if (is_lw) begin
            nxt = S_WRITEBACK;
          end else begin
            pc_load = 1'b1;
            nxt     = halt ? S_IDLE : S_FETCH;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          set_timeout = 1'b1;
          nxt         = S_ERROR;
        end
      end
      S_WRITEBACK: begin
        reg_write  = 1'b1;
        pc_load    = 1'b1;
        reg_dst_rd = is_rtype;
        mem_to_reg = is_lw;
        nxt        = halt ? S_IDLE : S_FETCH;
      end
      default: begin
        nxt = cur;
      end
    endcase
    retire = pc_load & ~set_illegal;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur      <= S_IDLE;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
      retired  <= '0;
    end else begin
      cur <= nxt;
      if ((nxt == cur) && (cur == S_FETCH || cur == S_MEMORY) && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (set_illegal) illegal <= 1'b1;
      if (set_timeout) timeout <= 1'b1;
      if (retire)      retired <= retired + 32'd1;
    end
  end

  assign state  = cur;
  assign busy   = (cur != S_IDLE) && (cur != S_HALTED) && (cur != S_ERROR);
  assign halted = (cur == S_HALTED);

endmodule

// File: doc/cycle_controller.md
CYCLE_CONTROLLER -- requirements
Module: cycle_controller

Interface
REQ-001 The block SHALL provide parameter TIMEOUT, default 15, giving the maximum number of consecutive mem_ready-low wait cycles before an error is raised.
REQ-002 The block SHALL provide port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL provide port run, input, 1 bit: leave IDLE and start fetching.
REQ-005 The block SHALL provide port halt, input, 1 bit: stop at the next instruction boundary.
REQ-006 The block SHALL provide ports opcode, input, 6 bits, and func, input, 6 bits: instruction fields, valid from DECODE onward.
REQ-007 The block SHALL provide port alu_zero, input, 1 bit: ALU zero flag, valid in EXECUTE.
REQ-008 The block SHALL provide port mem_ready, input, 1 bit: memory access completes in this cycle.
REQ-009 The block SHALL provide output strobes, 1 bit each: mem_read, mem_write, ir_load, pc_load, reg_write.
REQ-010 The block SHALL provide output selects: alu_src_imm (1 bit), reg_dst_rd (1 bit), mem_to_reg (1 bit), and pc_src (2 bits; 0 = increment, 1 = branch, 2 = jump).
REQ-011 The block SHALL provide status outputs: state (3 bits), busy (1 bit), halted (1 bit), illegal (1 bit, sticky), timeout (1 bit, sticky), and retired (32 bits).

Function
REQ-012 State encoding SHALL be: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALTED=6, ERROR=7.
REQ-013 Supported instructions SHALL be:
- R-type: opcode 000000
- addi: 001000
- lw: 100011
- sw: 101011
- beq: 000100
- j: 000010
- syscall: opcode 000000 with func 001100
REQ-014 IDLE SHALL go to FETCH when run=1 and halt=0; otherwise it SHALL remain in IDLE.
REQ-015 FETCH behaviour:
- mem_read=1 in every FETCH cycle.
- In the cycle with mem_ready=1: ir_load=1, and the next state is DECODE.
REQ-016 DECODE behaviour:
- One cycle, no strobes.
- Next state is EXECUTE for supported non-syscall instructions.
- Syscall: pc_load=1 with pc_src=0, retired increments, next state HALTED.
- Unsupported opcode: illegal is set, pc_load=1 with pc_src=0, retired does not change, next state FETCH.
REQ-017 EXECUTE behaviour:
- One cycle.
- alu_src_imm=1 for addi, lw and sw.
- beq: pc_load=1, pc_src=1 if alu_zero=1 else 0, next state FETCH.
- j: pc_load=1, pc_src=2, next state FETCH.
- R-type and addi: next state WRITEBACK.
- lw and sw: next state MEMORY.
REQ-018 MEMORY behaviour:
- lw: mem_read=1; sw: mem_write=1; alu_src_imm=1 is held.
- Strobes are held until the cycle with mem_ready=1.
- On that cycle: lw goes to WRITEBACK; sw asserts pc_load=1 with pc_src=0 and goes to FETCH.
REQ-019 WRITEBACK behaviour:
- One cycle: reg_write=1 and pc_load=1 with pc_src=0.
- reg_dst_rd=1 for R-type; mem_to_reg=1 for lw.
- Next state FETCH.
REQ-020 retired SHALL increment by 1 on each pc_load for a legal instruction, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-021 halt SHALL be sampled only in a cycle where pc_load=1.
- If halt=1, the next state is IDLE instead of FETCH.
- halt=1 in any other cycle SHALL have no effect.
REQ-022 Memory wait timeout:
- A wait counter SHALL count consecutive FETCH/MEMORY cycles with mem_ready=0.
- The counter SHALL clear on mem_ready=1 and on every state change.
- When it reaches TIMEOUT, the next state SHALL be ERROR and timeout SHALL be set.
- mem_ready=1 in the same cycle the count reaches TIMEOUT SHALL complete the access normally, with no error.
REQ-023 HALTED and ERROR SHALL be terminal.
- All strobes are 0 in both states.
- halted=1 in HALTED.
- Both states are exited only by reset.
REQ-024 Output timing:
- All strobe and select outputs SHALL be decoded from the current state and inputs (Mealy), with zero-cycle latency.
- All selects SHALL be 0 whenever they are not specified as asserted.
REQ-025 busy SHALL be 1 in states FETCH through WRITEBACK and 0 otherwise.

Reset
REQ-026 reset_n=0 SHALL asynchronously force:
- state = IDLE
- all strobes = 0 and all selects = 0
- illegal, timeout, halted and busy = 0
- retired = 0
- wait counter = 0
REQ-027 Reset asserted mid-access SHALL drop mem_read, mem_write and reg_write immediately, without waiting for a clock edge.
REQ-028 After reset_n rises, the block SHALL remain in IDLE until it sees run=1.

Verification
REQ-029 addi with mem_ready=1 every cycle: run=1 -> states 1,2,3,5,1; reg_write and pc_load pulse together in WRITEBACK; retired=1.
REQ-030 lw with a 2-cycle MEMORY stall -> mem_read held for 3 cycles; WRITEBACK shows mem_to_reg=1 and reg_write=1; total of 7 cycles from FETCH to the next FETCH.
REQ-031 beq -> with alu_zero=1, EXECUTE shows pc_src=1 and pc_load=1; with alu_zero=0, pc_src=0; WRITEBACK is never entered.
REQ-032 Opcode 111111, then a syscall -> illegal=1 and retired unchanged after the first; after the syscall, state=6, halted=1, retired=1, and run=1 does not restart the block.
REQ-033 FETCH with mem_ready held at 0 for TIMEOUT=15 cycles -> state=7, timeout=1; a variant with mem_ready=1 in cycle 15 -> normal DECODE, timeout=0.
REQ-034 halt=1 during EXECUTE of an sw, then reset_n pulsed low in a later FETCH -> no effect until the sw's pc_load, then state=0; the reset pulse clears all outputs asynchronously.
